// File: rtl/shift_issue_stage.sv
// Execute-stage front end for MIPS R-type shifts: decodes into S1, drives an external
// combinational barrel shifter, and registers its result into S2 behind a valid/ready handshake.
module shift_issue_stage #(
  parameter int n = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [n:0]   rs_val,
  input  logic [n:0]   rt_val,
  output logic [n:0]   sh_in,
  output logic [4:0]   sh_sl,
  output logic         sh_left_or_right,
  output logic         sh_logic_shift,
  output logic         sh_rotate_shift,
  output logic         sh_ariphmethic_shift,
  input  logic [n:0]   sh_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n:0]   out_data,
  output logic [4:0]   out_rd,
  output logic         out_we,
  output logic         out_illegal
);

  logic        w_legal;
  logic        w_right;
  logic        w_rot;
  logic        w_arith;
  logic [4:0]  w_sl;
  logic        w_s1_adv;
  logic        w_accept;
  logic        w_unused;

  logic        r_s1_valid;
  logic [n:0]  r_s1_rt;
  logic [4:0]  r_s1_sl;
  logic        r_s1_right;
  logic        r_s1_logic;
  logic        r_s1_rot;
  logic        r_s1_arith;
  logic [4:0]  r_s1_rd;
  logic        r_s1_we;
  logic        r_s1_illegal;

  logic        r_s2_valid;
  logic [n:0]  r_s2_data;
  logic [4:0]  r_s2_rd;
  logic        r_s2_we;
  logic        r_s2_illegal;

  // Fields the decoder never looks at; only the low five bits of rs act as a shift amount.
  assign w_unused = ^{rs_val[n:5], instr[25:22], instr[20:16]};

  always_comb begin
    w_legal = 1'b0;
    w_right = 1'b0;
    w_rot   = 1'b0;
    w_arith = 1'b0;
    w_sl    = 5'd0;
    if (instr[31:26] == 6'd0) begin
      case (instr[5:0])
        6'b000000: begin w_legal = 1'b1; w_sl = instr[10:6]; end
        6'b000010: begin w_legal = 1'b1; w_right = 1'b1; w_rot = instr[21]; w_sl = instr[10:6]; end
        6'b000011: begin w_legal = 1'b1; w_right = 1'b1; w_arith = 1'b1; w_sl = instr[10:6]; end
        6'b000100: begin w_legal = 1'b1; w_sl = rs_val[4:0]; end
        6'b000110: begin w_legal = 1'b1; w_right = 1'b1; w_rot = instr[6]; w_sl = rs_val[4:0]; end
        6'b000111: begin w_legal = 1'b1; w_right = 1'b1; w_arith = 1'b1; w_sl = rs_val[4:0]; end
        default:   w_legal = 1'b0;
      endcase
    end
  end

  assign w_s1_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept = in_valid && in_ready;

  // S1: decoded op; cleared when it drains so the kind bits read all-zero while empty
  always_ff @(posedge clk) begin
    if (rst || (!w_accept && w_s1_adv)) begin
      r_s1_valid   <= 1'b0;
      r_s1_rt      <= '0;
      r_s1_sl      <= 5'd0;
      r_s1_right   <= 1'b0;
      r_s1_logic   <= 1'b0;
      r_s1_rot     <= 1'b0;
      r_s1_arith   <= 1'b0;
      r_s1_rd      <= 5'd0;
      r_s1_we      <= 1'b0;
      r_s1_illegal <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid   <= 1'b1;
      r_s1_rt      <= rt_val;
      r_s1_sl      <= w_sl;
      r_s1_right   <= w_right;
      r_s1_logic   <= !w_rot && !w_arith;
      r_s1_rot     <= w_rot;
      r_s1_arith   <= w_arith;
      r_s1_rd      <= instr[15:11];
      r_s1_we      <= w_legal && (instr[15:11] != 5'd0);
      r_s1_illegal <= !w_legal;
    end
  end

  assign sh_in                = r_s1_rt;
  assign sh_sl                = r_s1_sl;
  assign sh_left_or_right     = r_s1_right;
  assign sh_logic_shift       = r_s1_logic;
  assign sh_rotate_shift      = r_s1_rot;
  assign sh_ariphmethic_shift = r_s1_arith;

  // S2: captured shifter result, held while writeback stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_data    <= '0;
      r_s2_rd      <= 5'd0;
      r_s2_we      <= 1'b0;
      r_s2_illegal <= 1'b0;
    end else if (r_s1_valid && w_s1_adv) begin
      r_s2_valid   <= 1'b1;
      r_s2_data    <= sh_out;
      r_s2_rd      <= r_s1_rd;
      r_s2_we      <= r_s1_we;
      r_s2_illegal <= r_s1_illegal;
    end else if (out_ready) begin
      r_s2_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_data    = r_s2_data;
  assign out_rd      = r_s2_rd;
  assign out_we      = r_s2_we;
  assign out_illegal = r_s2_illegal;

endmodule
